mux_sel_arbiter: RTL and testbench
==================================

Name: mux_sel_arbiter

Overview:
- Two-requester arbiter that sequences the shared 2:1 output mux.
- It drives the mux select: 1 selects the a-side and 0 selects the b-side.
- It grants one requester at a time with round-robin fairness, burst locking and a fairness timeout.
- The parent ties o_sel to the z signal of the mux-control interface instance.

Parameters:
- MAX_HOLD, 16: maximum beats one requester may hold the mux while the other is waiting. Legal range is 2..255.
- RESET_SEL, 1'b0: value of o_sel during and after reset.
- CNT_W, $clog2(MAX_HOLD): width of the beat counter (derived, not overridable).

Ports:
- i_clk  input  1  clock; all state changes on the rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_a_req  input  1  requester A wants the mux (level, held until served).
- i_a_last  input  1  A's current beat is the final beat of its burst.
- o_a_gnt  output  1  A owns the mux; a beat occurs when i_a_req & o_a_gnt.
- i_b_req  input  1  requester B wants the mux.
- i_b_last  input  1  B's current beat is the final beat of its burst.
- o_b_gnt  output  1  B owns the mux.
- o_sel  output  1  mux select (1 = A, 0 = B); registered.
- o_busy  output  1  a grant is active (o_a_gnt | o_b_gnt).

Behaviour:
- Reset (async assert, sync deassert by the parent):
  - state=IDLE; o_a_gnt=0, o_b_gnt=0, o_busy=0.
  - o_sel=RESET_SEL.
  - prio=0 (A wins the next tie); cnt=0.
- All outputs are registered; there is no combinational path from inputs to outputs.
- States are IDLE, GNT_A and GNT_B, in a 2-bit enum.
- In IDLE:
  - Request on A only → GNT_A.
  - Request on B only → GNT_B.
  - Both requesting → prio=0 goes to GNT_A, prio=1 goes to GNT_B.
  - Grant latency: the grant appears 1 cycle after the request is sampled.
- o_sel changes only on the same edge that asserts the new grant.
  - It holds its last value in IDLE, so the mux never glitches and never sees X.
- In GNT_X:
  - Each beat increments cnt, which saturates at MAX_HOLD-1.
  - Release condition 1: beat with i_x_last=1.
  - Release condition 2: i_x_req drops (abandon); no beat is counted.
  - Release condition 3: a beat with cnt==MAX_HOLD-1 while the other requester is asserting (timeout).
  - Timeout without a competitor does not release; the burst continues and cnt stays saturated.
- On release:
  - prio points to the other requester.
  - cnt clears.
  - Other requester asserting → go directly to GNT_other the next cycle, with no idle bubble; o_sel flips on that same edge.
  - Otherwise → IDLE. A re-request by the same requester is re-granted after one IDLE cycle.
- Invariants:
  - o_a_gnt and o_b_gnt are never both 1.
  - o_sel == 1 whenever o_a_gnt; o_sel == 0 whenever o_b_gnt.
- Simultaneous last and timeout on the same beat count as a single release; prio flips once.
- Reset asserted mid-burst: outputs go to their reset values immediately (asynchronously). The requester is responsible for restarting its burst.
- Out-of-range inputs:
  - i_x_last without i_x_req is ignored.
  - i_x_last while not granted is ignored.

Optional Feature:
- Macro: MUX_SEL_ARBITER_ASSERT_EN.
- Defined: an always_comb block carries assert final immediate assertions, each reporting via $error:
  - o_sel, o_a_gnt and o_b_gnt are not X after reset is deasserted (reduction-XOR !== 'x check).
  - The two grants are never both 1.
  - o_sel is consistent with the active grant.
- Not defined: no assertion code is compiled and the RTL function is identical.

Decomposition:
- Shared package mux_sel_pkg:
  - state enum typedef: IDLE, GNT_A, GNT_B.
  - localparam SEL_A=1'b1, SEL_B=1'b0.
  - The same constants are reused by the mux-side assertions.
- One natural sub-module, mux_sel_beat_cnt:
  - Saturating CNT_W counter with clear and increment inputs and an at_max output.
- FSM and priority logic stay in the top module.

Test Plan:
- Reset, then i_a_req=1 alone with a 3-beat burst (last on beat 3) → o_a_gnt=1 and o_sel=1 from cycle 2; o_a_gnt=0 after beat 3; state returns to IDLE and o_sel stays 1.
- A and B both request in the same cycle after reset → A is granted first; on A's last beat, B's grant follows with no bubble; o_sel goes 1→0 on the same edge.
- With MAX_HOLD=4, A streams with no last while B requests → A is released after its 4th beat; o_b_gnt=1 the next cycle; prio then favours A.
- A streams 20 beats with B idle → no release; cnt saturates at 3; grant is held until last.
- i_rst_n pulsed low mid-burst of B → o_b_gnt=0, o_busy=0 and o_sel=RESET_SEL asynchronously, without waiting for a clock edge.
- With MUX_SEL_ARBITER_ASSERT_EN defined, run random req/last for 10k cycles → zero assertion failures, grants mutually exclusive, o_sel always 0 or 1.

Source files
------------

// File: rtl/mux_sel_pkg.sv
// Shared types and select encodings for the 2:1 output-mux arbiter and its mux-side checks.
package mux_sel_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_e;

    localparam logic SEL_A = 1'b1;
    localparam logic SEL_B = 1'b0;

endpackage

// File: rtl/mux_sel_arbiter_if.sv
// Request/grant bundle between the two requesters and the mux arbiter.
interface mux_sel_arbiter_if;

    logic i_a_req;
    logic i_a_last;
    logic o_a_gnt;
    logic i_b_req;
    logic i_b_last;
    logic o_b_gnt;
    logic o_sel;
    logic o_busy;

    // master: requester/parent side; slave: the arbiter
    modport master (
        output i_a_req, i_a_last, i_b_req, i_b_last,
        input  o_a_gnt, o_b_gnt, o_sel, o_busy
    );

    modport slave (
        input  i_a_req, i_a_last, i_b_req, i_b_last,
        output o_a_gnt, o_b_gnt, o_sel, o_busy
    );

endinterface

// File: rtl/mux_sel_beat_cnt.sv
// Saturating beat counter for the current grant; at_max_c flags the fairness-timeout beat.
module mux_sel_beat_cnt #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic at_max_c
);

    localparam int unsigned CNT_W = $clog2(MAX_HOLD);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !at_max_c) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign at_max_c = (cnt == CNT_MAX);

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin two-requester arbiter driving the shared 2:1 mux select, with burst lock and timeout.
// Optional checks compiled in with MUX_SEL_ARBITER_ASSERT_EN.
module mux_sel_arbiter
    import mux_sel_pkg::*;
#(
    parameter int unsigned MAX_HOLD  = 16,
    parameter logic        RESET_SEL = 1'b0
) (
    input logic               i_clk,
    input logic               i_rst_n,
    mux_sel_arbiter_if.slave  bus
);

    state_e state;
    state_e state_nxt;
    logic   prio;
    logic   prio_nxt;
    logic   a_gnt;
    logic   b_gnt;
    logic   sel;
    logic   busy;
    logic   cnt_clr;
    logic   cnt_inc;
    logic   at_max_c;
    logic   rel;

    mux_sel_beat_cnt #(
        .MAX_HOLD (MAX_HOLD)
    ) u_beat_cnt (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .clr      (cnt_clr),
        .inc      (cnt_inc),
        .at_max_c (at_max_c)
    );

    // Next-state, priority and counter control; a granted requester that drops req releases without a beat
    always_comb begin
        state_nxt = state;
        prio_nxt  = prio;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        rel       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.i_a_req && (!bus.i_b_req || !prio)) begin
                    state_nxt = GNT_A;
                end else if (bus.i_b_req) begin
                    state_nxt = GNT_B;
                end
            end
            GNT_A: begin
                if (!bus.i_a_req || bus.i_a_last || (at_max_c && bus.i_b_req)) begin
                    rel = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
                if (rel) begin
                    cnt_clr   = 1'b1;
                    prio_nxt  = 1'b1;
                    state_nxt = bus.i_b_req ? GNT_B : IDLE;
                end
            end
            GNT_B: begin
                if (!bus.i_b_req || bus.i_b_last || (at_max_c && bus.i_a_req)) begin
                    rel = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
                if (rel) begin
                    cnt_clr   = 1'b1;
                    prio_nxt  = 1'b0;
                    state_nxt = bus.i_a_req ? GNT_A : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_clr   = 1'b1;
            end
        endcase
    end

    // Outputs are registered from the next state so sel moves on the very edge that raises the grant
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            prio  <= 1'b0;
            a_gnt <= 1'b0;
            b_gnt <= 1'b0;
            busy  <= 1'b0;
            sel   <= RESET_SEL;
        end else begin
            state <= state_nxt;
            prio  <= prio_nxt;
            a_gnt <= (state_nxt == GNT_A);
            b_gnt <= (state_nxt == GNT_B);
            busy  <= (state_nxt != IDLE);
            if (state_nxt == GNT_A) begin
                sel <= SEL_A;
            end else if (state_nxt == GNT_B) begin
                sel <= SEL_B;
            end
        end
    end

    assign bus.o_a_gnt = a_gnt;
    assign bus.o_b_gnt = b_gnt;
    assign bus.o_sel   = sel;
    assign bus.o_busy  = busy;

`ifdef MUX_SEL_ARBITER_ASSERT_EN
    always_comb begin
        if (i_rst_n) begin
            a_no_x: assert final ((^{sel, a_gnt, b_gnt}) !== 1'bx)
                else $error("sel/grant unknown after reset");
            a_excl: assert final (!(a_gnt && b_gnt))
                else $error("both grants active");
            a_sel_a: assert final (!a_gnt || (sel == SEL_A))
                else $error("sel not on A while A granted");
            a_sel_b: assert final (!b_gnt || (sel == SEL_B))
                else $error("sel not on B while B granted");
        end
    end
`endif

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed self-checking bench for mux_sel_arbiter (MAX_HOLD=4, RESET_SEL=1).
module tb_mux_sel_arbiter;

    localparam int unsigned MAX_HOLD  = 4;
    localparam logic        RESET_SEL = 1'b1;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    mux_sel_arbiter_if bus ();

    mux_sel_arbiter #(
        .MAX_HOLD  (MAX_HOLD),
        .RESET_SEL (RESET_SEL)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic a_req, input logic a_last, input logic b_req, input logic b_last);
        bus.i_a_req  = a_req;
        bus.i_a_last = a_last;
        bus.i_b_req  = b_req;
        bus.i_b_last = b_last;
    endtask

    task automatic expect_out(input string tag, input logic a, input logic b, input logic s, input logic bsy);
        check({tag, ".a_gnt"}, bus.o_a_gnt, a);
        check({tag, ".b_gnt"}, bus.o_b_gnt, b);
        check({tag, ".sel"},   bus.o_sel,   s);
        check({tag, ".busy"},  bus.o_busy,  bsy);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) cyc();
        expect_out("reset", 1'b0, 1'b0, RESET_SEL, 1'b0);
        rst_n = 1'b1;
        cyc();
        expect_out("idle", 1'b0, 1'b0, RESET_SEL, 1'b0);

        // A alone, three-beat burst
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        cyc();
        expect_out("a3.grant", 1'b1, 1'b0, 1'b1, 1'b1);
        cyc();
        cyc();
        check("a3.beat2", bus.o_a_gnt, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        cyc();
        expect_out("a3.release", 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        expect_out("a3.idle", 1'b0, 1'b0, 1'b1, 1'b0);

        // Tie after reset: A first, then B with no bubble
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        cyc();
        expect_out("tie.a", 1'b1, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        cyc();
        expect_out("tie.handover", 1'b0, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        cyc();
        expect_out("tie.b_done", 1'b0, 1'b0, 1'b0, 1'b0);

        // Same requester re-request: one idle cycle, then re-grant; then abandon
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        cyc();
        check("rereq.grant", bus.o_a_gnt, 1'b1);
        cyc();
        check("rereq.idle", bus.o_a_gnt, 1'b0);
        cyc();
        check("rereq.regrant", bus.o_a_gnt, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        expect_out("abandon", 1'b0, 1'b0, 1'b1, 1'b0);

        // Timeout: A streams while B waits, released after beat MAX_HOLD
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        cyc();
        check("to.grant", bus.o_a_gnt, 1'b1);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i < int'(MAX_HOLD); i++) begin
            cyc();
            check("to.hold", bus.o_a_gnt, 1'b1);
        end
        cyc();
        expect_out("to.handover", 1'b0, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        cyc();
        expect_out("to.back_a", 1'b1, 1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        check("to.idle", bus.o_busy, 1'b0);

        // prio now favours B on a tie
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        cyc();
        expect_out("prio.b", 1'b0, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        cyc();
        check("prio.to_a", bus.o_a_gnt, 1'b1);

        // A streams 20 beats uncontested; saturated counter releases on first contested beat
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cyc();
            check("sat.hold", bus.o_a_gnt, 1'b1);
        end
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        cyc();
        expect_out("sat.release", 1'b0, 1'b1, 1'b0, 1'b1);

        // a_last without a_req and while not granted is ignored
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        cyc();
        expect_out("stray_last", 1'b0, 1'b1, 1'b0, 1'b1);

        // Async reset mid-burst of B
        #2;
        rst_n = 1'b0;
        #1;
        expect_out("async_rst", 1'b0, 1'b0, RESET_SEL, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // Random traffic, checking grant exclusivity and select consistency
        for (int i = 0; i < 500; i++) begin
            drive(1'($urandom_range(1)), 1'($urandom_range(1)),
                  1'($urandom_range(1)), 1'($urandom_range(1)));
            cyc();
            check("rnd.excl", bus.o_a_gnt & bus.o_b_gnt, 1'b0);
            check("rnd.busy", bus.o_busy, bus.o_a_gnt | bus.o_b_gnt);
            if (bus.o_a_gnt) check("rnd.sel_a", bus.o_sel, 1'b1);
            if (bus.o_b_gnt) check("rnd.sel_b", bus.o_sel, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
